fsab_rr_scheduler: RTL

- Fair round-robin grant scheduler for the FSAB request path.
- Sits between per-device request FIFOs and the shared outbound FSAB bus. It replaces the fixed highest-index-wins selection with rotating priority.
- Tracks outbound bus credits, issues a one-cycle start pulse to the chosen FIFO, and holds the grant until that FIFO drops its active flag.
- Adds a watchdog on stuck grants and sticky error flags for timeout and credit overflow.

---
 rtl/fsab_rr_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fsab_rr_scheduler.sv
// Round-robin grant scheduler for the FSAB request path: rotating priority,
// outbound credit tracking, stuck-grant watchdog and sticky error flags.
module fsab_rr_scheduler #(
  parameter int DEVICES         = 3,
  parameter int IDX_W           = 2,
  parameter int CREDITS_W       = 4,
  parameter int INITIAL_CREDITS = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DEVICES-1:0]   req,
  input  logic [DEVICES-1:0]   active,
  input  logic                 credit_in,
  output logic [DEVICES-1:0]   start,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic [CREDITS_W-1:0] credits,
  output logic                 err_timeout,
  output logic                 err_credit_ovf
);

  localparam int                   WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]      WD_LAST   = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic                 WD_EN     = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [CREDITS_W-1:0] CRED_MAX  = {CREDITS_W{1'b1}};
  localparam logic [CREDITS_W-1:0] CRED_INIT = CREDITS_W'(INITIAL_CREDITS);
  localparam logic [IDX_W-1:0]     LAST_INIT = IDX_W'(DEVICES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACT = 2'd1,
    BUSY     = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [DEVICES-1:0]   start_r, start_s;
  logic                 grant_valid_r, grant_valid_s;
  logic [IDX_W-1:0]     grant_idx_r, grant_idx_s;
  logic [IDX_W-1:0]     last_r, last_s;
  logic [WD_W-1:0]      wdog_r, wdog_s, wdog_inc_s;
  logic [CREDITS_W-1:0] credits_r, credits_s;
  logic                 err_timeout_r, err_timeout_s;
  logic                 err_credit_ovf_r, err_credit_ovf_s;
  logic [IDX_W:0]       pick_s;
  logic                 act_sel_s;
  logic                 start_fired_s;

  // Returns {found, index} of the first requester after 'last', wrapping modulo
  // DEVICES. Scanning from the far end lets the nearest candidate overwrite.
  function automatic logic [IDX_W:0] rr_pick(input logic [DEVICES-1:0] r,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] res;
    int             cand;
    res = '0;
    for (int k = DEVICES; k >= 1; k--) begin
      cand = (int'(last) + k) % DEVICES;
      res  = (|(r & (DEVICES'(1) << cand))) ? {1'b1, IDX_W'(cand)} : res;
    end
    return res;
  endfunction

  assign pick_s        = rr_pick(req, last_r);
  assign act_sel_s     = |(active & (DEVICES'(1) << grant_idx_r));
  assign start_fired_s = |start_r;
  assign wdog_inc_s    = WD_EN ? (wdog_r + WD_W'(1)) : wdog_r;

  // Grant state machine: selection in IDLE, hold until release or watchdog expiry
  always_comb begin
    state_s       = state_r;
    start_s       = '0;
    grant_valid_s = grant_valid_r;
    grant_idx_s   = grant_idx_r;
    last_s        = last_r;
    wdog_s        = wdog_r;
    err_timeout_s = err_timeout_r;
    case (state_r)
      IDLE: begin
        if (pick_s[IDX_W] && (credits_r != '0)) begin
          state_s       = WAIT_ACT;
          start_s       = DEVICES'(1) << pick_s[IDX_W-1:0];
          grant_idx_s   = pick_s[IDX_W-1:0];
          grant_valid_s = 1'b1;
          wdog_s        = '0;
        end else begin
          state_s       = IDLE;
        end
      end
      WAIT_ACT, BUSY: begin
        // A normal release in BUSY takes precedence over a coincident expiry.
        if ((state_r == BUSY) && !act_sel_s) begin
          state_s       = IDLE;
          grant_valid_s = 1'b0;
          last_s        = grant_idx_r;
        end else if (WD_EN && (wdog_r == WD_LAST)) begin
          state_s       = IDLE;
          grant_valid_s = 1'b0;
          last_s        = grant_idx_r;
          err_timeout_s = 1'b1;
        end else if ((state_r == WAIT_ACT) && act_sel_s) begin
          state_s       = BUSY;
          wdog_s        = wdog_inc_s;
        end else begin
          wdog_s        = wdog_inc_s;
        end
      end
      default: begin
        state_s       = IDLE;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // Credit counter: consume on a start pulse, refund on credit_in, saturate at max
  always_comb begin
    credits_s        = credits_r;
    err_credit_ovf_s = err_credit_ovf_r;
    if (start_fired_s && !credit_in) begin
      credits_s = credits_r - CREDITS_W'(1);
    end else if (!start_fired_s && credit_in) begin
      if (credits_r == CRED_MAX) begin
        err_credit_ovf_s = 1'b1;
      end else begin
        credits_s = credits_r + CREDITS_W'(1);
      end
    end else begin
      credits_s = credits_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      start_r          <= '0;
      grant_valid_r    <= 1'b0;
      grant_idx_r      <= '0;
      last_r           <= LAST_INIT;
      wdog_r           <= '0;
      credits_r        <= CRED_INIT;
      err_timeout_r    <= 1'b0;
      err_credit_ovf_r <= 1'b0;
    end else begin
      state_r          <= state_s;
      start_r          <= start_s;
      grant_valid_r    <= grant_valid_s;
      grant_idx_r      <= grant_idx_s;
      last_r           <= last_s;
      wdog_r           <= wdog_s;
      credits_r        <= credits_s;
      err_timeout_r    <= err_timeout_s;
      err_credit_ovf_r <= err_credit_ovf_s;
    end
  end

  assign start          = start_r;
  assign grant_valid    = grant_valid_r;
  assign grant_idx      = grant_idx_r;
  assign credits        = credits_r;
  assign err_timeout    = err_timeout_r;
  assign err_credit_ovf = err_credit_ovf_r;

endmodule
